// File: rtl/pattern_pkg.sv
// Shared encodings for the pattern-generator bank: scroll modes, bounce states, default colours.
package pattern_pkg;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned COLOR_W = 6;

  typedef enum logic [1:0] {
    MODE_H      = 2'd0,
    MODE_V      = 2'd1,
    MODE_D      = 2'd2,
    MODE_BOUNCE = 2'd3
  } mode_e;

  typedef enum logic {
    ST_FWD = 1'b0,
    ST_REV = 1'b1
  } bounce_st_e;

  localparam logic [COLOR_W-1:0] COLOR_A_DEF = 6'b110000;
  localparam logic [COLOR_W-1:0] COLOR_B_DEF = 6'b000000;

endpackage

// File: rtl/frame_event_queue.sv
// Saturating count of outstanding frame-advance requests; one is retired per consume while non-empty.
module frame_event_queue #(
  parameter int unsigned PEND_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              consume,
  output logic              nonempty,
  output logic [PEND_W-1:0] pend
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic take;

  assign nonempty = (pend != '0);
  assign take     = consume && nonempty;

  // Simultaneous inc and take cancel out, so a request is never dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
    end else begin
      case ({inc, take})
        2'b10:   if (pend != PEND_MAX) pend <= pend + PEND_W'(1);
        2'b01:   pend <= pend - PEND_W'(1);
        default: pend <= pend;
      endcase
    end
  end

endmodule

// File: rtl/scroll_checker_gen.sv
// Scrolling two-colour checkerboard with horizontal, vertical, diagonal and bounce modes.
module scroll_checker_gen
  import pattern_pkg::*;
#(
  parameter int unsigned TILE_LOG2  = 4,
  parameter int unsigned OFFSET_W   = 8,
  parameter int unsigned PEND_W     = 4,
  parameter int unsigned BOUNCE_MAX = 128,
  parameter logic [5:0]  COLOR_A    = COLOR_A_DEF,
  parameter logic [5:0]  COLOR_B    = COLOR_B_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       active,
  input  logic       next_frame,
  input  logic [1:0] mode,
  input  logic [2:0] speed,
  output logic [5:0] rgb,
  output logic       dir_rev
);

  localparam logic [OFFSET_W:0]   BMAX_EXT = (OFFSET_W+1)'(BOUNCE_MAX);
  localparam logic [OFFSET_W-1:0] BMAX_OFF = OFFSET_W'(BOUNCE_MAX);

  logic [OFFSET_W-1:0] off_x;
  logic [OFFSET_W-1:0] off_y;
  logic [PEND_W-1:0]   pend;
  mode_e               mode_q;
  bounce_st_e          bst;

  logic                sof;
  logic                nonempty;
  logic                apply;
  mode_e               mode_in;
  logic [OFFSET_W-1:0] s;
  logic [OFFSET_W:0]   fwd_sum;

  assign sof     = (x == 10'd0) && (y == 10'd0);
  assign apply   = sof && nonempty;
  assign mode_in = mode_e'(mode);
  assign s       = OFFSET_W'(speed);
  assign fwd_sum = {1'b0, off_x} + {1'b0, s};
  assign dir_rev = (bst == ST_REV);

  frame_event_queue #(
    .PEND_W (PEND_W)
  ) u_queue (
    .clk      (clk),
    .rst      (rst),
    .inc      (next_frame),
    .consume  (sof),
    .nonempty (nonempty),
    .pend     (pend)
  );

  // Offsets and bounce state change only on a consuming frame start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      off_x  <= '0;
      off_y  <= '0;
      mode_q <= MODE_H;
      bst    <= ST_FWD;
    end else if (apply) begin
      mode_q <= mode_in;
      if (mode_in == MODE_BOUNCE && mode_q != MODE_BOUNCE) begin
        off_x <= '0;
        bst   <= ST_FWD;
      end else if (mode_in != MODE_BOUNCE) begin
        bst <= ST_FWD;
        case (mode_in)
          MODE_H:  off_x <= off_x + s;
          MODE_V:  off_y <= off_y + s;
          default: begin
            off_x <= off_x + s;
            off_y <= off_y + s;
          end
        endcase
      end else if (s != '0) begin
        case (bst)
          ST_FWD: begin
            if (fwd_sum >= BMAX_EXT) begin
              off_x <= BMAX_OFF;
              bst   <= ST_REV;
            end else begin
              off_x <= fwd_sum[OFFSET_W-1:0];
            end
          end
          default: begin
            if (off_x <= s) begin
              off_x <= '0;
              bst   <= ST_FWD;
            end else begin
              off_x <= off_x - s;
            end
          end
        endcase
      end
    end
  end

  logic [9:0] sx;
  logic [9:0] sy;
  logic       tile;

  // Zero-latency pixel path; coordinates wrap at 1024.
  assign sx   = x + 10'(off_x);
  assign sy   = y + 10'(off_y);
  assign tile = sx[TILE_LOG2] ^ sy[TILE_LOG2];
  assign rgb  = !active ? 6'd0 : (tile ? COLOR_A : COLOR_B);

endmodule

// File: tb/tb_scroll_checker_gen.sv
// Directed bench for scroll_checker_gen with hand-computed expectations.
module tb_scroll_checker_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] x;
  logic [9:0] y;
  logic       active;
  logic       next_frame;
  logic [1:0] mode;
  logic [2:0] speed;
  logic [5:0] rgb;
  logic       dir_rev;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] CA = 32'd48;
  localparam logic [31:0] CB = 32'd0;

  scroll_checker_gen dut (
    .clk        (clk),
    .rst        (rst),
    .x          (x),
    .y          (y),
    .active     (active),
    .next_frame (next_frame),
    .mode       (mode),
    .speed      (speed),
    .rgb        (rgb),
    .dir_rev    (dir_rev)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_nf();
    x = 10'd5; y = 10'd5;
    next_frame = 1'b1;
    tick();
    next_frame = 1'b0;
  endtask

  task automatic do_sof();
    x = 10'd0; y = 10'd0;
    tick();
    x = 10'd5; y = 10'd5;
  endtask

  task automatic advance();
    pulse_nf();
    do_sof();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; x = '0; y = '0; active = 1'b0;
    next_frame = 1'b0; mode = 2'd0; speed = 3'd0;
    #12;
    chk("rst_off_x", 32'(dut.off_x), 0);
    chk("rst_off_y", 32'(dut.off_y), 0);
    chk("rst_pend", 32'(dut.u_queue.pend), 0);
    chk("rst_dir_rev", 32'(dir_rev), 0);
    chk("rst_rgb_inactive", 32'(rgb), CB);
    rst = 1'b0;
    tick();

    // Basic horizontal scroll
    mode = 2'd0; speed = 3'd1; active = 1'b1;
    x = 10'd16; y = 10'd0; #1;
    chk("rgb_x16", 32'(rgb), CA);
    pulse_nf(); pulse_nf(); pulse_nf();
    chk("pend_3", 32'(dut.u_queue.pend), 3);
    do_sof(); do_sof(); do_sof();
    chk("h_off_x_3", 32'(dut.off_x), 3);
    chk("h_pend_0", 32'(dut.u_queue.pend), 0);
    x = 10'd13; y = 10'd0; #1;
    chk("rgb_x13", 32'(rgb), CA);
    x = 10'd12; #1;
    chk("rgb_x12", 32'(rgb), CB);

    // Saturation: 20 requests, 16 frames, 15 advances
    do_reset();
    chk("rst2_off_x", 32'(dut.off_x), 0);
    for (int i = 0; i < 20; i++) pulse_nf();
    chk("pend_sat", 32'(dut.u_queue.pend), 15);
    for (int i = 0; i < 16; i++) do_sof();
    chk("sat_off_x", 32'(dut.off_x), 15);
    chk("sat_pend_0", 32'(dut.u_queue.pend), 0);

    // Request coincident with consume
    pulse_nf(); pulse_nf();
    x = 10'd0; y = 10'd0; next_frame = 1'b1;
    tick();
    next_frame = 1'b0;
    chk("coinc_pend", 32'(dut.u_queue.pend), 2);
    chk("coinc_off_x", 32'(dut.off_x), 16);
    do_sof(); do_sof();
    chk("drain_off_x", 32'(dut.off_x), 18);
    chk("drain_pend", 32'(dut.u_queue.pend), 0);
    // Request on a sof with empty queue is not consumed that cycle
    x = 10'd0; y = 10'd0; next_frame = 1'b1;
    tick();
    next_frame = 1'b0;
    chk("empty_sof_pend", 32'(dut.u_queue.pend), 1);
    chk("empty_sof_off_x", 32'(dut.off_x), 18);
    do_sof();
    chk("empty_sof_later", 32'(dut.off_x), 19);
    // Saturated queue plus consume stays at max
    for (int i = 0; i < 16; i++) pulse_nf();
    x = 10'd0; y = 10'd0; next_frame = 1'b1;
    tick();
    next_frame = 1'b0;
    chk("sat_coinc_pend", 32'(dut.u_queue.pend), 15);
    chk("sat_coinc_off_x", 32'(dut.off_x), 20);
    for (int i = 0; i < 15; i++) do_sof();
    chk("sat_drain_off_x", 32'(dut.off_x), 35);

    // Bounce mode
    do_reset();
    mode = 2'd3; speed = 3'd7;
    advance();
    chk("b_enter_off_x", 32'(dut.off_x), 0);
    chk("b_enter_dir", 32'(dir_rev), 0);
    for (int k = 1; k <= 18; k++) begin
      advance();
      chk("b_fwd_off_x", 32'(dut.off_x), 32'(7 * k));
      chk("b_fwd_dir", 32'(dir_rev), 0);
    end
    advance();
    chk("b_top_off_x", 32'(dut.off_x), 128);
    chk("b_top_dir", 32'(dir_rev), 1);
    for (int k = 1; k <= 18; k++) begin
      advance();
      chk("b_rev_off_x", 32'(dut.off_x), 32'(128 - 7 * k));
      chk("b_rev_dir", 32'(dir_rev), 1);
    end
    advance();
    chk("b_bottom_off_x", 32'(dut.off_x), 0);
    chk("b_bottom_dir", 32'(dir_rev), 0);
    chk("b_off_y_frozen", 32'(dut.off_y), 0);
    speed = 3'd0;
    advance();
    chk("b_s0_off_x", 32'(dut.off_x), 0);
    // Leave bounce while reversing
    speed = 3'd7;
    for (int i = 0; i < 19; i++) advance();
    chk("b_top2_dir", 32'(dir_rev), 1);
    mode = 2'd0; speed = 3'd0;
    advance();
    chk("b_exit_off_x", 32'(dut.off_x), 128);
    chk("b_exit_dir", 32'(dir_rev), 0);
    // Re-entering bounce resets off_x without a step
    mode = 2'd3; speed = 3'd7;
    advance();
    chk("b_reenter_off_x", 32'(dut.off_x), 0);

    // Diagonal wrap and mid-frame mode change
    do_reset();
    mode = 2'd2; speed = 3'd4;
    for (int i = 0; i < 32; i++) advance();
    chk("d_half_x", 32'(dut.off_x), 128);
    chk("d_half_y", 32'(dut.off_y), 128);
    for (int i = 0; i < 32; i++) advance();
    chk("d_wrap_x", 32'(dut.off_x), 0);
    chk("d_wrap_y", 32'(dut.off_y), 0);
    advance();
    pulse_nf();
    mode = 2'd1;
    tick(); tick();
    chk("mid_off_x", 32'(dut.off_x), 4);
    chk("mid_off_y", 32'(dut.off_y), 4);
    do_sof();
    chk("v_off_x", 32'(dut.off_x), 4);
    chk("v_off_y", 32'(dut.off_y), 8);

    // Pixel path with both offsets
    x = 10'd12; y = 10'd0; #1;
    chk("rgb_xy_a", 32'(rgb), CA);
    x = 10'd12; y = 10'd8; #1;
    chk("rgb_xy_b", 32'(rgb), CB);
    x = 10'd4; y = 10'd8; #1;
    chk("rgb_xy_c", 32'(rgb), CA);
    active = 1'b0; x = 10'd12; y = 10'd0; #1;
    chk("rgb_inactive", 32'(rgb), CB);
    active = 1'b1;

    // Asynchronous reset mid-line
    pulse_nf(); pulse_nf();
    x = 10'd300; y = 10'd7;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_off_x", 32'(dut.off_x), 0);
    chk("arst_off_y", 32'(dut.off_y), 0);
    chk("arst_pend", 32'(dut.u_queue.pend), 0);
    tick();
    rst = 1'b0;
    tick();
    do_sof();
    chk("arst_queue_lost", 32'(dut.off_x), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
